// File: rtl/rpn_pkg.sv
// Shared constants for the RPN controller, its ALU and the attached stack.
//   Stack commands : CMD_NOP / CMD_CLR / CMD_PUSH / CMD_POP (2-bit stack cmd port)
//   Opcodes        : OP_ADD / OP_SUB / OP_AND / OP_XOR (operator token data[1:0])
//   Controller FSM : ST_* state encodings
package rpn_pkg;

  localparam int unsigned CMD_W = 2;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned ST_W  = 3;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_PUSH = 2'b10;
  localparam logic [1:0] CMD_POP  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PUSHV = 3'd2;
  localparam logic [2:0] ST_POPB  = 3'd3;
  localparam logic [2:0] ST_POPA  = 3'd4;
  localparam logic [2:0] ST_CAP   = 3'd5;
  localparam logic [2:0] ST_PUSHR = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Token stream handshake into the RPN controller.
//   tok_valid : token present (source -> controller)
//   tok_ready : controller accepts on valid & ready at a rising edge
//   tok_is_op : 1 = operator, 0 = operand
//   tok_data  : operand value, or opcode in [1:0]
interface rpn_stack_ctrl_if #(
  parameter int unsigned DW = 8
);

  logic          tok_valid;
  logic          tok_ready;
  logic          tok_is_op;
  logic [DW-1:0] tok_data;

  modport master (
    output tok_valid,
    output tok_is_op,
    output tok_data,
    input  tok_ready
  );

  modport slave (
    input  tok_valid,
    input  tok_is_op,
    input  tok_data,
    output tok_ready
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational RPN arithmetic, all modulo 2^DW.
//   a  : deeper operand
//   b  : top-of-stack operand
//   op : opcode (ADD, SUB a-b, AND, XOR)
//   r  : result
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [OP_W-1:0] op,
  output logic [DW-1:0]   r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = DW'(a + b);
      OP_SUB:  r = DW'(a - b);
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer: turns a token stream into NOP/CLR/PUSH/POP commands
// for an external DEPTH x DW stack and evaluates binary operators.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous soft clear (abort, empty stack, clear err)
//   tok        : token handshake (slave side)
//   stk_cmd    : stack command; stk_din / stk_dout / stk_error to/from stack
//   res_valid  : one-cycle pulse while an operator result is pushed
//   res_data   : last operator result
//   depth      : believed stack occupancy
//   err        : sticky error flag (underflow, overflow, stack error)
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  rpn_stack_ctrl_if.slave    tok,
  output logic [CMD_W-1:0]   stk_cmd,
  output logic [DW-1:0]      stk_din,
  input  logic [DW-1:0]      stk_dout,
  input  logic               stk_error,
  output logic               res_valid,
  output logic [DW-1:0]      res_data,
  output logic [CW-1:0]      depth,
  output logic               err
);

  logic [ST_W-1:0]  state,     state_nxt;
  logic [CMD_W-1:0] cmd_nxt;
  logic [DW-1:0]    din_nxt;
  logic             res_valid_nxt;
  logic [DW-1:0]    res_data_nxt;
  logic [CW-1:0]    depth_nxt;
  logic             err_nxt;
  logic             ready_q,   ready_nxt;
  logic [DW-1:0]    b_q,       b_nxt;
  logic [OP_W-1:0]  op_q,      op_nxt;
  logic [DW-1:0]    alu_r;

  assign tok.tok_ready = ready_q;

  // A comes straight from stk_dout during CAP; B was captured a cycle earlier.
  rpn_alu #(.DW(DW)) u_alu (
    .a  (stk_dout),
    .b  (b_q),
    .op (op_q),
    .r  (alu_r)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      stk_cmd   <= CMD_NOP;
      stk_din   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      depth     <= '0;
      err       <= 1'b0;
      ready_q   <= 1'b0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      state     <= state_nxt;
      stk_cmd   <= cmd_nxt;
      stk_din   <= din_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      depth     <= depth_nxt;
      err       <= err_nxt;
      ready_q   <= ready_nxt;
      b_q       <= b_nxt;
      op_q      <= op_nxt;
    end
  end

  // Next state and the output values that go with it.
  always_comb begin
    state_nxt     = state;
    cmd_nxt       = CMD_NOP;
    din_nxt       = stk_din;
    res_valid_nxt = 1'b0;
    res_data_nxt  = res_data;
    depth_nxt     = depth;
    err_nxt       = err;
    ready_nxt     = 1'b0;
    b_nxt         = b_q;
    op_nxt        = op_q;

    if (clr) begin
      state_nxt = ST_INIT;
      cmd_nxt   = CMD_CLR;
      depth_nxt = '0;
      err_nxt   = 1'b0;
    end else if (stk_error && (state != ST_INIT)) begin
      state_nxt = ST_ERR;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        // Out of reset the CLR has not been shown yet; after clr it already has.
        ST_INIT: begin
          if (stk_cmd == CMD_CLR) begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
          end else begin
            cmd_nxt = CMD_CLR;
          end
        end
        ST_IDLE: begin
          ready_nxt = 1'b1;
          if (tok.tok_valid && ready_q) begin
            ready_nxt = 1'b0;
            if (!tok.tok_is_op) begin
              if (depth < CW'(DEPTH)) begin
                state_nxt = ST_PUSHV;
                cmd_nxt   = CMD_PUSH;
                din_nxt   = tok.tok_data;
              end else begin
                state_nxt = ST_ERR;
                err_nxt   = 1'b1;
              end
            end else begin
              if (depth >= CW'(2)) begin
                state_nxt = ST_POPB;
                cmd_nxt   = CMD_POP;
                op_nxt    = tok.tok_data[OP_W-1:0];
              end else begin
                state_nxt = ST_ERR;
                err_nxt   = 1'b1;
              end
            end
          end
        end
        ST_PUSHV: begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
          depth_nxt = depth + CW'(1);
        end
        ST_POPB: begin
          state_nxt = ST_POPA;
          cmd_nxt   = CMD_POP;
        end
        ST_POPA: begin
          state_nxt = ST_CAP;
          b_nxt     = stk_dout;
        end
        ST_CAP: begin
          state_nxt     = ST_PUSHR;
          cmd_nxt       = CMD_PUSH;
          din_nxt       = alu_r;
          res_valid_nxt = 1'b1;
          res_data_nxt  = alu_r;
        end
        ST_PUSHR: begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
          depth_nxt = depth - CW'(1);
        end
        ST_ERR: begin
          state_nxt = ST_ERR;
        end
        default: begin
          state_nxt = ST_INIT;
          cmd_nxt   = CMD_CLR;
        end
      endcase
    end
  end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Upstream command sequencer for the 8-deep x 8-bit `stack` block. It is the only driver of that block's `cmd` and `data_in`.
- Accepts a token stream of operands and operators (valid/ready). Converts each token into NOP/CLR/PUSH/POP sequences on the stack port and performs 8-bit RPN arithmetic.
- Keeps its own depth count, so underflow and overflow are caught before any illegal stack command is issued.

Parameters:
- DEPTH, 8, stack capacity in entries; must match the attached stack.
- DW, 8, data width.
- CW, 4, width of the depth counter; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous soft clear: abort, empty stack, clear err.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted when tok_valid & tok_ready at a rising edge.
- tok_is_op  in  1  1 = operator token, 0 = operand token.
- tok_data  in  DW  operand value, or opcode in [1:0]: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- stk_cmd  out  2  to stack cmd: 00 NOP, 01 CLR, 10 PUSH, 11 POP.
- stk_din  out  DW  to stack data_in.
- stk_dout  in  DW  from stack data_out.
- stk_error  in  1  from stack error.
- res_valid  out  1  one-cycle pulse when an operator result is pushed.
- res_data  out  DW  result value; holds its last value otherwise.
- depth  out  CW  number of entries the controller believes are on the stack.
- err  out  1  sticky error flag.

Behaviour:
- Stack contract: the stack executes stk_cmd at a rising edge. After a POP edge, stk_dout holds the popped value for the next full cycle.
- All outputs are registered (Moore).
- Reset (async): state=INIT, stk_cmd=NOP, stk_din=0, res_valid=0, res_data=0, depth=0, err=0, tok_ready=0.
- States and transitions:
  - INIT: stk_cmd=CLR for one cycle (the stack has no reset), then IDLE.
  - IDLE: tok_ready=1, stk_cmd=NOP.
    - Operand with depth<DEPTH: latch value, go to PUSHV.
    - Operand with depth==DEPTH: err=1, go to ERR.
    - Operator with depth>=2: latch opcode, go to POPB.
    - Operator with depth<2: err=1, go to ERR. No POP is issued.
  - PUSHV: stk_cmd=PUSH, stk_din=operand; depth+1 at the exit edge; then IDLE. Operand cost: 2 cycles, IDLE to IDLE.
  - POPB: stk_cmd=POP (pops B, the top entry); then POPA.
  - POPA: stk_cmd=POP; capture B from stk_dout at the exit edge; then CAP.
  - CAP: stk_cmd=NOP; capture A from stk_dout; compute R; then PUSHR.
  - PUSHR: stk_cmd=PUSH, stk_din=R, res_valid=1, res_data=R; depth-1 net at the exit edge; then IDLE. Operator cost: 5 cycles.
  - ERR: tok_ready=0, stk_cmd=NOP; leave only via clr or rst.
- Arithmetic, all modulo 2^DW with no carry/borrow out:
  - ADD: A+B. SUB: A-B (A is the deeper operand). AND: A&B. XOR: A^B.
- tok_ready is 0 in every state except IDLE, so a token is never accepted mid-operation.
- stk_error sampled high in any non-INIT state: err=1, go to ERR. This is a consistency backstop and must never fire in legal use.
- clr has priority over everything, including tok_valid in IDLE and operations in flight. Next state is INIT, depth=0, err=0, res_valid=0, and any partial operands are discarded.
- rst mid-operation: immediate return to reset values. The stack contents are discarded by INIT.

Decomposition:
- Shared package `rpn_pkg` holds:
  - stack command constants NOP/CLR/PUSH/POP (also used by the stack and its bench);
  - opcode constants ADD/SUB/AND/XOR;
  - the state enum.
- One sub-module, `rpn_alu`: combinational, inputs (a, b, op), output r.

Test Plan:
- Reset, then observe: one CLR cycle on stk_cmd, then tok_ready=1 with depth=0 and err=0.
- Push 0x03, push 0x05, ADD -> stk_cmd sequence PUSH,PUSH,POP,POP,NOP,PUSH; res_valid pulse with res_data=0x08; depth=1.
- Push 0x02, push 0x05, SUB -> res_data=0xFD. Push 0xF0, ADD -> res_data=0xED (wrap).
- ADD immediately after reset -> err=1; no POP ever issued; tok_ready=0. Then clr -> CLR issued, err=0, depth=0.
- Push 0x01..0x08 -> depth=8. Ninth operand 0x09 -> err=1 with no PUSH issued. Stack stk_error never asserts.
- Assert clr during POPA of an operation -> next cycle stk_cmd=CLR, no res_valid pulse, depth=0. Push 0x10, push 0x20, XOR -> res_data=0x30.
